// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, with
// valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fa_sum_s;
  logic             fa_cout_s;

  fa_cell u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand shifters, running carry, sum accumulator and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          // LSB-first: each new sum bit enters at the top and walks down.
          sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= fa_cout_s;
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        DONE: begin
          sum_sh_r <= sum_sh_r;
          carry_r  <= carry_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign start_ready = (state_r == IDLE);
  assign done_valid  = (state_r == DONE);
  assign busy        = (state_r == RUN) || (state_r == DONE);
  assign sum         = sum_sh_r;
  assign cout        = carry_r;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in. It accepts operands through a valid/ready handshake, holds the running carry in a register between bit steps, and returns the WIDTH-bit sum and carry-out through a second valid/ready handshake. It sits between an operand source and a result consumer as the area-minimal alternative to a parallel ripple adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  operands a, b, cin valid
- start_ready  out  1  controller can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled on the accept edge only
- b  in  WIDTH  operand B, sampled on the accept edge only
- cin  in  1  carry-in, sampled on the accept edge only
- sum  out  WIDTH  result sum, stable while done_valid is high
- cout  out  1  carry out of bit WIDTH-1
- done_valid  out  1  sum/cout valid
- done_ready  in  1  consumer accepts the result
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: start_ready=1. On start_valid&&start_ready:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0
  - clear sum_sh
  - go to RUN
- RUN, each cycle:
  - the fa_cell computes {c,s} = a_sh[0]+b_sh[0]+carry
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}
  - a_sh, b_sh shift right by 1 with zero fill
  - carry <= c, cnt <= cnt+1
  - when cnt==WIDTH-1, also go to DONE
- DONE:
  - done_valid=1
  - sum=sum_sh, cout=carry, both held unchanged
  - on done_ready, go to IDLE
- start_valid is ignored outside IDLE. No new operands are accepted in the same cycle as done_ready (no overlap).
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry-out, so {cout,sum} = a+b+cin exactly.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1, so it never wraps.
- Reset mid-operation (RUN or DONE):
  - immediate return to IDLE
  - the in-flight result is discarded
  - no done_valid pulse is produced
- Reset values:
  - done_valid=0, busy=0, sum=0, cout=0, start_ready=1
  - all internal registers are 0

## Timing
- Accept edge at cycle k; RUN occupies cycles k+1..k+WIDTH; done_valid rises after edge k+WIDTH.
- Latency from accept to done_valid is WIDTH cycles.
- done_valid stays high until the edge where done_ready=1. It falls on that edge, and start_ready rises on the same edge.
- Minimum issue interval is WIDTH+2 cycles with done_ready tied high: 1 accept, WIDTH run, 1 done.
- start_ready, done_valid and busy are decoded from registered state only. They have no combinational path from start_valid or done_ready.
- sum and cout are registered outputs and never glitch within a cycle.

## Structure
- Package serial_adder_pkg:
  - state_t enum {IDLE, RUN, DONE} (2 bits)
  - localparam DEFAULT_WIDTH=8
- Sub-module fa_cell: purely combinational 1-bit full adder.
  - inputs a, b, cin; outputs sum, cout
  - sum = a^b^cin; cout = a&b | cin&(a^b)
  - instantiated once
- All sequencing, shift registers, the carry flop and the counter live in serial_adder_ctrl.

## Test plan
- Reset, then idle 5 cycles -> start_ready=1, busy=0, done_valid=0, sum=0, cout=0 throughout.
- WIDTH=8, a=0x0F, b=0x01, cin=0, done_ready=1 -> done_valid exactly 8 cycles after accept, sum=0x10, cout=0. Next accept is possible 10 cycles after the first.
- a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1. Also run an exhaustive 4-bit sweep with WIDTH=4 (all a, b, cin; 512 cases) checking {cout,sum}=a+b+cin.
- Hold done_ready=0 for 6 cycles after done_valid while toggling start_valid and changing a/b:
  - done_valid, sum and cout stay stable
  - start_ready stays 0
  - on done_ready=1, done_valid falls and start_ready rises on the same edge
- Assert rst at RUN cycle 3 of 8, deassert asynchronously mid-cycle:
  - outputs reset immediately; done_valid never pulses
  - state is IDLE, and the next operands a=0x55, b=0xAA, cin=0 give sum=0xFF, cout=0
- start_valid held high continuously with done_ready=1 -> exactly one accept per WIDTH+2 cycles; busy is low only on accept cycles.
